// File: rtl/nibble_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : nibble_serial_adder (with cla4_slice)
// Brief    : Multi-cycle WIDTH-bit adder. Operands stream one nibble per
//            clock through a single 4-bit carry-lookahead slice. The ripple
//            carry between nibbles is resolved from the slice's group p/g.
// Revision : 1.0 - initial release
// ============================================================================

// 4-bit carry-lookahead slice: sum nibble plus group propagate/generate.
module cla4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c,
  output logic [3:0] s,
  output logic       p,
  output logic       g
);
  logic [3:0] w_p;
  logic [3:0] w_g;
  logic [3:0] w_c;

  assign w_p = a ^ b;
  assign w_g = a & b;

  // Internal carries are computed in lookahead form, not rippled.
  assign w_c[0] = c;
  assign w_c[1] = w_g[0] | (w_p[0] & c);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & c);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & c);

  assign s = w_p ^ w_c;
  assign p = &w_p;
  assign g = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
           | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
endmodule

module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int N  = WIDTH / 4;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_NIB = CW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q,  state_d;
  logic [WIDTH-1:0] a_sh_q,   a_sh_d;
  logic [WIDTH-1:0] b_sh_q,   b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic [WIDTH-1:0] sum_q,    sum_d;
  logic [CW-1:0]    cnt_q,    cnt_d;
  logic             c_q,      c_d;
  logic             cout_q,   cout_d;
  logic             ovf_q,    ovf_d;
  logic             a_msb_q,  a_msb_d;
  logic             b_msb_q,  b_msb_d;

  logic [3:0] w_slice_s;
  logic       w_slice_p;
  logic       w_slice_g;
  logic       w_c_next;

  cla4_slice u_slice (
    .a (a_sh_q[3:0]),
    .b (b_sh_q[3:0]),
    .c (c_q),
    .s (w_slice_s),
    .p (w_slice_p),
    .g (w_slice_g)
  );

  // Carry into the next nibble from the slice's group propagate/generate.
  assign w_c_next = w_slice_g | (w_slice_p & c_q);

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

  // Next-state, datapath updates and status outputs for the sequencing FSM.
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    sum_d    = sum_q;
    cnt_d    = cnt_q;
    c_d      = c_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    busy     = 1'b0;
    done     = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        done = (state_q == S_DONE);
        if (start) begin
          // Accepting edge: capture operands; sum/cout/ovf keep last result.
          a_sh_d   = a;
          b_sh_d   = b;
          c_d      = cin;
          cnt_d    = '0;
          sum_sh_d = '0;
          a_msb_d  = a[WIDTH-1];
          b_msb_d  = b[WIDTH-1];
          state_d  = S_RUN;
        end else begin
          state_d  = S_IDLE;
        end
      end

      S_RUN: begin
        busy     = 1'b1;
        a_sh_d   = a_sh_q >> 4;
        b_sh_d   = b_sh_q >> 4;
        sum_sh_d = {w_slice_s, sum_sh_q[WIDTH-1:4]};
        c_d      = w_c_next;
        if (cnt_q == LAST_NIB) begin
          // Last nibble: publish the result directly, no extra stage.
          sum_d   = {w_slice_s, sum_sh_q[WIDTH-1:4]};
          cout_d  = w_c_next;
          ovf_d   = (a_msb_q == b_msb_q) && (w_slice_s[3] != a_msb_q);
          state_d = S_DONE;
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      sum_q    <= '0;
      cnt_q    <= '0;
      c_q      <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      sum_q    <= sum_d;
      cnt_q    <= cnt_d;
      c_q      <= c_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
    end
  end
endmodule
`default_nettype wire
